mem_ioctrl: RTL
===============

Name: mem_ioctrl

Overview:
Memory/IO controller that sits directly downstream of the memory arbiter and serves its single-request pulse/ack interface (mem_read, mem_write, mem_ack). It decodes each request to either an external asynchronous word-wide SRAM or a small bank of memory-mapped IO registers. It sequences SRAM timing with a programmable wait-state counter and returns a one-cycle mem_ack per accepted request.

Parameters:
SRAM_AW, 18, SRAM word-address width; SRAM byte range is 0 .. 4*2^SRAM_AW-1.
WAIT_STATES, 2, extra SRAM access cycles; legal range 0..15.
LED_W, 8, width of the LED output register.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
mem_read  in  1  read request; one-cycle pulse from the arbiter
mem_write  in  1  write request; one-cycle pulse from the arbiter
mem_addr  in  32  byte address, valid with the request pulse
mem_data_write  in  32  write data, valid with the request pulse
mem_ack  out  1  one-cycle completion pulse, registered
mem_data_read  out  32  read data, valid while mem_ack=1, registered
sram_addr  out  SRAM_AW  SRAM word address
sram_dq_o  out  32  SRAM write data
sram_dq_i  in  32  SRAM read data
sram_dq_oe  out  1  1 = drive SRAM data bus (tristate enable, applied at the pad)
sram_ce_n  out  1  chip enable, active low
sram_oe_n  out  1  output enable, active low
sram_we_n  out  1  write enable, active low
led  out  LED_W  LED register contents

Behaviour:
- Reset (async, any state, including mid-access):
  - state=IDLE; mem_ack=0; mem_data_read=0.
  - sram_ce_n=sram_oe_n=sram_we_n=1; sram_dq_oe=0; sram_addr=0; sram_dq_o=0.
  - led=0; cycle counter=0.
  - An aborted transaction is never acknowledged.
- Request acceptance:
  - Requests are sampled only in IDLE. Let edge E be the sampling edge.
  - On accept, latch addr and data.
  - mem_read and mem_write both high: write taken, read dropped.
  - Pulses arriving outside IDLE are ignored; there is no queue.
- Decode:
  - mem_addr[31]=0: SRAM access, sram_addr=mem_addr[SRAM_AW+1:2]. Higher bits alias; addr[1:0] ignored.
  - mem_addr[31]=1: IO access selected by mem_addr[3:2].
    - 00: LED register (RW). Write stores data[LED_W-1:0]; read returns it zero-extended.
    - 01: cycle counter (RO). Read returns the counter value at edge E.
    - 10/11: read returns 0; write discarded.
- States:
  - IDLE
  - IO: one cycle. Perform the register op, set mem_ack -> IDLE.
  - RD: ce_n=0, oe_n=0 from edge E. Counter loaded with WAIT_STATES and decremented each cycle. In the cycle the counter is 0, sample sram_dq_i into mem_data_read at the next edge, set mem_ack -> IDLE.
  - WR_SETUP: ce_n=0, dq_oe=1, addr/dq_o driven, we_n=1, one cycle -> WR_PULSE.
  - WR_PULSE: we_n=0 for WAIT_STATES+1 cycles -> WR_HOLD.
  - WR_HOLD: we_n=1, ce_n=0, dq_oe=1, one cycle; set mem_ack -> IDLE.
  - ACK is a one-cycle register pulse. ce_n, oe_n and dq_oe return to 1/1/0 on the same edge mem_ack rises.
- Latency L (mem_ack high in the cycle starting at edge E+L):
  - IO: L=1.
  - SRAM read: L=WAIT_STATES+1.
  - SRAM write: L=WAIT_STATES+3.
  - Defaults: read=3, write=5.
- mem_ack is never high on two consecutive cycles. mem_data_read holds its value until the next read completes; writes do not change it.
- Cycle counter: 32-bit, increments every cycle, wraps 0xFFFFFFFF -> 0.
- sram_we_n and sram_oe_n are never low simultaneously. sram_dq_oe=1 only in WR_* states.

Test Plan:
- Write 0xDEADBEEF to 0x00000010, then read 0x00000010 (WAIT_STATES=2). Required: write ack 5 cycles after sampling, with we_n low exactly 3 cycles and addr=4. Read ack 3 cycles after sampling, with mem_data_read=0xDEADBEEF.
- Write 0x000001A5 to 0x80000000, then read 0x80000000. Required: led=0xA5; read returns 0x000000A5; each ack arrives at L=1.
- Read 0x80000004 twice, 10 cycles apart. Required: the second value minus the first equals 10. Force the counter near 0xFFFFFFFF and read again: the returned value wraps to a small value.
- Read 0x8000000C. Required: returns 0 with L=1. Write to 0x80000008: led is unchanged.
- Pulse mem_read and mem_write together (addr 0x20, data 0x12345678). Required: the write executes, only one ack is issued, and SRAM word 8 = 0x12345678. Also inject a pulse during an SRAM read: it is ignored, with no extra ack.
- Assert reset during WR_PULSE. Required: we_n, ce_n and oe_n are immediately 1, dq_oe=0, mem_ack never rises, and led=0. A subsequent read completes normally.

Source files
------------

// File: rtl/mem_ioctrl.sv
// mem_ioctrl: arbiter-side controller that routes single pulse requests to an async SRAM or a small IO register bank
// Ports:
//   clk, reset                       system clock, asynchronous active-high reset
//   mem_read, mem_write              one-cycle request pulses from the arbiter (write wins if both)
//   mem_addr, mem_data_write         byte address and write data, valid with the pulse
//   mem_ack, mem_data_read           registered one-cycle completion pulse and read data
//   sram_addr, sram_dq_o, sram_dq_i  SRAM word address, write data, read data
//   sram_dq_oe                       data bus drive enable for the pad tristate
//   sram_ce_n, sram_oe_n, sram_we_n  active-low SRAM strobes
//   led                              LED register contents
module mem_ioctrl #(
  parameter int SRAM_AW     = 18,
  parameter int WAIT_STATES = 2,
  parameter int LED_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [31:0]        mem_addr,
  input  logic [31:0]        mem_data_write,
  output logic               mem_ack,
  output logic [31:0]        mem_data_read,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [31:0]        sram_dq_o,
  input  logic [31:0]        sram_dq_i,
  output logic               sram_dq_oe,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic [LED_W-1:0]   led
);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  typedef enum logic [2:0] {S_IDLE, S_IO, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD} state_t;
  state_t             r_state;
  logic [3:0]         r_wait;
  logic [31:0]        r_cnt;
  logic [31:0]        r_snap;
  logic [LED_W-1:0]   r_wdata;
  logic [1:0]         r_sel;
  logic               r_wr;
  logic               r_ack;
  logic [31:0]        r_rdata;
  logic [SRAM_AW-1:0] r_addr;
  logic [31:0]        r_dq_o;
  logic               r_dq_oe;
  logic               r_ce_n;
  logic               r_oe_n;
  logic               r_we_n;
  logic [LED_W-1:0]   r_led;
  logic               w_req;
  logic               w_unused;
  assign w_req    = mem_read | mem_write;
  // only a few address bits decode; upper SRAM bits alias and byte offset is ignored
  assign w_unused = &{1'b0, mem_addr};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_wait  <= '0;
      r_cnt   <= '0;
      r_snap  <= '0;
      r_wdata <= '0;
      r_sel   <= '0;
      r_wr    <= 1'b0;
      r_ack   <= 1'b0;
      r_rdata <= '0;
      r_addr  <= '0;
      r_dq_o  <= '0;
      r_dq_oe <= 1'b0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_led   <= '0;
    end else begin
      r_cnt <= r_cnt + 32'd1;
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: if (w_req) begin
          r_wr    <= mem_write;
          r_sel   <= mem_addr[3:2];
          r_wdata <= mem_data_write[LED_W-1:0];
          r_snap  <= r_cnt;
          r_wait  <= WS;
          if (mem_addr[31]) r_state <= S_IO;
          else begin
            // strobes go active on the accept edge so SRAM timing starts immediately
            r_addr <= mem_addr[SRAM_AW+1:2];
            r_ce_n <= 1'b0;
            if (mem_write) begin
              r_dq_o  <= mem_data_write;
              r_dq_oe <= 1'b1;
              r_state <= S_WR_SETUP;
            end else begin
              r_oe_n  <= 1'b0;
              r_state <= S_RD;
            end
          end
        end
        S_IO: begin
          if (r_wr) begin
            if (r_sel == 2'd0) r_led <= r_wdata;
          end else r_rdata <= (r_sel == 2'd0) ? 32'(r_led) : (r_sel == 2'd1) ? r_snap : 32'd0;
          r_ack   <= 1'b1;
          r_state <= S_IDLE;
        end
        S_RD: if (r_wait == 4'd0) begin
          r_rdata <= sram_dq_i;
          r_ack   <= 1'b1;
          r_ce_n  <= 1'b1;
          r_oe_n  <= 1'b1;
          r_state <= S_IDLE;
        end else r_wait <= r_wait - 4'd1;
        S_WR_SETUP: begin
          r_we_n  <= 1'b0;
          r_state <= S_WR_PULSE;
        end
        S_WR_PULSE: if (r_wait == 4'd0) begin
          r_we_n  <= 1'b1;
          r_state <= S_WR_HOLD;
        end else r_wait <= r_wait - 4'd1;
        S_WR_HOLD: begin
          r_ack   <= 1'b1;
          r_ce_n  <= 1'b1;
          r_dq_oe <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign mem_ack       = r_ack;
  assign mem_data_read = r_rdata;
  assign sram_addr     = r_addr;
  assign sram_dq_o     = r_dq_o;
  assign sram_dq_oe    = r_dq_oe;
  assign sram_ce_n     = r_ce_n;
  assign sram_oe_n     = r_oe_n;
  assign sram_we_n     = r_we_n;
  assign led           = r_led;
endmodule
